// File: rtl/exec_mem_stage_pkg.sv
// Shared types for the execute/memory boundary: datapath words, opcodes,
// the captured stage entry and the stage FSM encoding.
package exec_mem_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [XLEN-1:0] addr_t;
    typedef logic [5:0]      opcode_t;
    typedef logic [4:0]      i5;

    localparam opcode_t OP_SPECIAL = 6'h00;
    localparam opcode_t OP_LUI     = 6'h0F;
    localparam opcode_t OP_LB      = 6'h20;
    localparam opcode_t OP_LH      = 6'h21;
    localparam opcode_t OP_LW      = 6'h23;
    localparam opcode_t OP_LBU     = 6'h24;
    localparam opcode_t OP_LHU     = 6'h25;
    localparam opcode_t OP_SB      = 6'h28;
    localparam opcode_t OP_SH      = 6'h29;
    localparam opcode_t OP_SW      = 6'h2B;

    // Everything the memory stage needs from one executed instruction.
    typedef struct packed {
        addr_t   pc;
        word_t   aluout;
        opcode_t opcode;
        word_t   wdata;
        i5       dst;
        i5       exc;
        addr_t   erraddr;
        logic    hi_write;
        word_t   hi_data;
        logic    lo_write;
        word_t   lo_data;
    } ex_mem_t;

    typedef enum logic [0:0] {StEmpty, StFull} stage_state_e;

    function automatic logic is_mem_op(opcode_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/exec_mem_stage_hilo_regs.sv
// Architectural HI/LO registers with a commit port and a forwarding mux that
// lets execute see a pending HI/LO write still sitting in the stage register.
module hilo_regs
    import exec_mem_stage_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  commit,
    input  logic  held_ok,
    input  logic  hi_write,
    input  word_t hi_data,
    input  logic  lo_write,
    input  word_t lo_data,
    output word_t hi_fwd,
    output word_t lo_fwd
);

    word_t hi_q;
    word_t lo_q;

    // Commit HI/LO when a non-faulting entry leaves the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (hi_write) hi_q <= hi_data;
            if (lo_write) lo_q <= lo_data;
        end
    end

    // Held, non-faulting write wins over the committed value.
    always_comb begin
        hi_fwd = (held_ok && hi_write) ? hi_data : hi_q;
        lo_fwd = (held_ok && lo_write) ? lo_data : lo_q;
    end

endmodule

// File: rtl/exec_mem_stage.sv
// Execute -> memory pipeline register. Single-entry EMPTY/FULL stage that
// absorbs MUL/DIV stalls and flushes, owns HI/LO and counts MDU stall cycles.
module exec_mem_stage
    import exec_mem_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             mul_div_stall,
    input  addr_t            ex_pc,
    input  word_t            ex_aluout,
    input  opcode_t          ex_opcode,
    input  word_t            ex_wdata,
    input  i5                ex_dst,
    input  i5                ex_exc,
    input  addr_t            ex_erraddr,
    input  logic             ex_hi_write,
    input  word_t            ex_hi_data,
    input  logic             ex_lo_write,
    input  word_t            ex_lo_data,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             mem_valid,
    output logic             mem_en,
    output addr_t            mem_pc,
    output word_t            mem_aluout,
    output word_t            mem_wdata,
    output addr_t            mem_erraddr,
    output opcode_t          mem_opcode,
    output i5                mem_dst,
    output i5                mem_exc,
    output word_t            hi_fwd,
    output word_t            lo_fwd,
    output logic [CNT_W-1:0] mdu_stall_cnt
);

    stage_state_e     state_q, state_d;
    ex_mem_t          entry_q, entry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, cap, leave, entry_ok, commit;

    // Handshake: accept when empty or when the held entry drains this cycle.
    always_comb begin
        full     = (state_q == StFull);
        ex_ready = ~full | mem_ready;
        cap      = ex_valid & ex_ready & ~mul_div_stall & ~flush;
        leave    = full & mem_ready;
        entry_ok = (entry_q.exc == '0);
        commit   = leave & ~flush & entry_ok;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StEmpty;
        else       state_q <= state_d;
    end

    // FSM next state; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (cap) state_d = StFull;
            StFull:  if (leave && !cap) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        if (flush) state_d = StEmpty;
    end

    // FSM outputs: registered entry presented to the memory stage.
    always_comb begin
        mem_valid   = full;
        mem_pc      = entry_q.pc;
        mem_aluout  = entry_q.aluout;
        mem_wdata   = entry_q.wdata;
        mem_erraddr = entry_q.erraddr;
        mem_opcode  = entry_q.opcode;
        mem_exc     = entry_q.exc;
        // A faulting op must neither access memory nor write a GPR.
        mem_en      = full & is_mem_op(entry_q.opcode) & entry_ok;
        mem_dst     = entry_ok ? entry_q.dst : '0;
    end

    // Entry next value: load on capture, clear whenever the stage empties.
    always_comb begin
        entry_d = entry_q;
        if (cap) begin
            entry_d = '{pc: ex_pc, aluout: ex_aluout, opcode: ex_opcode, wdata: ex_wdata,
                        dst: ex_dst, exc: ex_exc, erraddr: ex_erraddr,
                        hi_write: ex_hi_write, hi_data: ex_hi_data,
                        lo_write: ex_lo_write, lo_data: ex_lo_data};
        end else if (state_d == StEmpty) begin
            entry_d = '0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) entry_q <= '0;
        else       entry_q <= entry_d;
    end

    // Saturating count of cycles execute waits on the MDU.
    always_comb begin
        cnt_d = cnt_q;
        if (ex_valid && mul_div_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        mdu_stall_cnt = cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    hilo_regs u_hilo_regs (
        .clk      (clk),
        .reset    (reset),
        .commit   (commit),
        .held_ok  (full & entry_ok),
        .hi_write (entry_q.hi_write),
        .hi_data  (entry_q.hi_data),
        .lo_write (entry_q.lo_write),
        .lo_data  (entry_q.lo_data),
        .hi_fwd   (hi_fwd),
        .lo_fwd   (lo_fwd)
    );

endmodule

// File: tb/tb_exec_mem_stage.sv
// Bench for exec_mem_stage: directed scenarios plus random traffic compared
// cycle by cycle against a single-slot transaction model.
module tb_exec_mem_stage;
    import exec_mem_stage_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid, ex_ready, mul_div_stall, flush, mem_ready;
    addr_t            ex_pc, ex_erraddr, mem_pc, mem_erraddr;
    word_t            ex_aluout, ex_wdata, ex_hi_data, ex_lo_data;
    word_t            mem_aluout, mem_wdata, hi_fwd, lo_fwd;
    opcode_t          ex_opcode, mem_opcode;
    i5                ex_dst, ex_exc, mem_dst, mem_exc;
    logic             ex_hi_write, ex_lo_write, mem_valid, mem_en;
    logic [CNT_W-1:0] mdu_stall_cnt;

    always #5 clk = ~clk;

    exec_mem_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mul_div_stall(mul_div_stall), .ex_pc(ex_pc), .ex_aluout(ex_aluout),
        .ex_opcode(ex_opcode), .ex_wdata(ex_wdata), .ex_dst(ex_dst), .ex_exc(ex_exc),
        .ex_erraddr(ex_erraddr), .ex_hi_write(ex_hi_write), .ex_hi_data(ex_hi_data),
        .ex_lo_write(ex_lo_write), .ex_lo_data(ex_lo_data), .flush(flush),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_en(mem_en), .mem_pc(mem_pc),
        .mem_aluout(mem_aluout), .mem_wdata(mem_wdata), .mem_erraddr(mem_erraddr),
        .mem_opcode(mem_opcode), .mem_dst(mem_dst), .mem_exc(mem_exc),
        .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .mdu_stall_cnt(mdu_stall_cnt)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: at most one instruction in flight, plus HI/LO and counter.
    logic        m_valid;
    ex_mem_t     m_ent;
    word_t       m_hi, m_lo;
    int unsigned m_cnt;

    task automatic model_reset();
        m_valid = 1'b0;
        m_ent   = '0;
        m_hi    = '0;
        m_lo    = '0;
        m_cnt   = 0;
    endtask

    function automatic logic m_is_mem(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    endfunction

    // Apply one clock edge worth of rules to the model using current inputs.
    task automatic model_clock();
        logic accept, drains;
        accept = ex_valid && (!m_valid || mem_ready) && !mul_div_stall && !flush;
        drains = m_valid && mem_ready;
        if (ex_valid && mul_div_stall && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        if (drains && !flush && m_ent.exc == 0) begin
            if (m_ent.hi_write) m_hi = m_ent.hi_data;
            if (m_ent.lo_write) m_lo = m_ent.lo_data;
        end
        if (flush) begin
            m_valid = 1'b0;
        end else if (accept) begin
            m_valid = 1'b1;
            m_ent   = '{pc: ex_pc, aluout: ex_aluout, opcode: ex_opcode, wdata: ex_wdata,
                        dst: ex_dst, exc: ex_exc, erraddr: ex_erraddr,
                        hi_write: ex_hi_write, hi_data: ex_hi_data,
                        lo_write: ex_lo_write, lo_data: ex_lo_data};
        end else if (drains) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic pend_ok;
        pend_ok = m_valid && m_ent.exc == 0;
        check_eq("m_valid", mem_valid, m_valid);
        check_eq("m_ready", ex_ready, !m_valid || mem_ready);
        check_eq("m_hi_fwd", hi_fwd, (pend_ok && m_ent.hi_write) ? m_ent.hi_data : m_hi);
        check_eq("m_lo_fwd", lo_fwd, (pend_ok && m_ent.lo_write) ? m_ent.lo_data : m_lo);
        check_eq("m_cnt", mdu_stall_cnt, m_cnt);
        if (m_valid) begin
            check_eq("m_pc", mem_pc, m_ent.pc);
            check_eq("m_aluout", mem_aluout, m_ent.aluout);
            check_eq("m_wdata", mem_wdata, m_ent.wdata);
            check_eq("m_opcode", mem_opcode, m_ent.opcode);
            check_eq("m_exc", mem_exc, m_ent.exc);
            check_eq("m_erraddr", mem_erraddr, m_ent.erraddr);
            check_eq("m_dst", mem_dst, (m_ent.exc == 0) ? m_ent.dst : 5'd0);
            check_eq("m_en", mem_en, m_is_mem(m_ent.opcode) && m_ent.exc == 0);
        end else begin
            check_eq("m_en_idle", mem_en, 1'b0);
        end
    endtask

    // One clock: inputs already driven; sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] alu,
                          input logic [4:0] dst, input logic [4:0] exc,
                          input logic [31:0] erraddr, input logic hw, input logic [31:0] hd,
                          input logic lw, input logic [31:0] ld);
        ex_pc = pc; ex_opcode = op; ex_aluout = alu; ex_wdata = alu ^ 32'h5A5A_5A5A;
        ex_dst = dst; ex_exc = exc; ex_erraddr = erraddr;
        ex_hi_write = hw; ex_hi_data = hd; ex_lo_write = lw; ex_lo_data = ld;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] prod;
        reset = 1'b1; ex_valid = 0; mul_div_stall = 0; flush = 0; mem_ready = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", mem_valid, 1'b0);
        check_eq("rst_aluout", mem_aluout, 32'h0);
        check_eq("rst_hi", hi_fwd, 32'h0);
        check_eq("rst_lo", lo_fwd, 32'h0);
        check_eq("rst_cnt", mdu_stall_cnt, 4'd0);
        check_eq("rst_ready", ex_ready, 1'b1);
        @(negedge clk) reset = 1'b0;

        // ADDU result 5 appears one cycle later, not a memory op.
        set_ex(32'h100, OP_SPECIAL, 32'h5, 5'd3, 0, 0, 0, 0, 0, 0);
        ex_valid = 1; mem_ready = 1;
        step();
        check_eq("addu_valid", mem_valid, 1'b1);
        check_eq("addu_alu", mem_aluout, 32'h5);
        check_eq("addu_en", mem_en, 1'b0);
        ex_valid = 0;
        step();

        // MULT held off by the MDU for 4 cycles, then captured and committed.
        prod = 64'h1_0000 * 64'h1_0000;
        set_ex(32'h104, OP_SPECIAL, 0, 0, 0, 0, 1, prod[63:32], 1, prod[31:0]);
        ex_valid = 1; mul_div_stall = 1;
        repeat (4) step();
        check_eq("mult_nocap", mem_valid, 1'b0);
        check_eq("mult_cnt", mdu_stall_cnt, 4'd4);
        mul_div_stall = 0; mem_ready = 0;
        step();
        check_eq("mult_held", mem_valid, 1'b1);
        check_eq("mult_hi_fwd", hi_fwd, 32'h1);
        ex_valid = 0; mem_ready = 1;
        step();
        check_eq("mult_left", mem_valid, 1'b0);
        check_eq("mult_hi", hi_fwd, 32'h1);
        check_eq("mult_lo", lo_fwd, 32'h0);

        // Faulting LW: no memory access, no GPR write, BadVAddr passed through.
        set_ex(32'h108, OP_LW, 32'h8000_0002, 5'd7, 5'h4, 32'h8000_0002, 0, 0, 0, 0);
        ex_valid = 1;
        step();
        check_eq("lw_exc", mem_exc, 5'h4);
        check_eq("lw_en", mem_en, 1'b0);
        check_eq("lw_dst", mem_dst, 5'd0);
        check_eq("lw_erraddr", mem_erraddr, 32'h8000_0002);
        ex_valid = 0;
        step();

        // MTHI held while memory stalls, then flushed: HI must keep its old value.
        set_ex(32'h10C, OP_SPECIAL, 32'h40, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        ex_valid = 1; mem_ready = 0;
        step();
        ex_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_valid", mem_valid, 1'b1);
            check_eq("hold_alu", mem_aluout, 32'h40);
            check_eq("hold_hi_fwd", hi_fwd, 32'hDEAD_BEEF);
        end
        flush = 1;
        step();
        flush = 0;
        check_eq("flush_valid", mem_valid, 1'b0);
        check_eq("flush_hi", hi_fwd, 32'h1);

        // Back-to-back captures at full throughput.
        mem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            set_ex(32'h200 + 4 * i, OP_SW, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0);
            ex_valid = 1;
            #1;
            check_eq("b2b_ready", ex_ready, 1'b1);
            step();
            check_eq("b2b_alu", mem_aluout, 32'h100 + i);
            check_eq("b2b_en", mem_en, 1'b1);
        end
        ex_valid = 0;
        step();

        // Reset asserted while FULL with a pending LO write.
        set_ex(32'h300, OP_SPECIAL, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        ex_valid = 1; mem_ready = 0;
        step();
        check_eq("pre_rst_lo", lo_fwd, 32'h1234_5678);
        ex_valid = 0;
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", mem_valid, 1'b0);
        check_eq("mid_rst_lo", lo_fwd, 32'h0);
        check_eq("mid_rst_hi", hi_fwd, 32'h0);
        model_reset();
        @(negedge clk) reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] ops [5];
            ops = '{OP_SPECIAL, OP_LW, OP_SW, OP_LBU, OP_LUI};
            set_ex($urandom, ops[$urandom_range(0, 4)], $urandom, 5'($urandom),
                   ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                   $urandom, 1'($urandom), $urandom, 1'($urandom), $urandom);
            ex_valid      = ($urandom_range(0, 3) != 0);
            mul_div_stall = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            mem_ready     = ($urandom_range(0, 2) != 0);
            step();
        end

        // Counter must stick at all-ones.
        flush = 0; ex_valid = 1; mul_div_stall = 1;
        repeat (20) step();
        check_eq("cnt_sat", mdu_stall_cnt, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
